// File: rtl/maze_pkg.sv
// Shared maze definitions: tile values, move directions, controller states and
// default maze geometry used by the generator, player controller and renderer.
package maze_pkg;
  localparam logic FLOOR = 1'b0;
  localparam logic WALL  = 1'b1;

  localparam int MAZE_WIDTH  = 30;
  localparam int MAZE_HEIGHT = 40;
  localparam int ADDR_W      = 11;
  localparam int COORD_W     = 6;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  typedef enum logic [2:0] {S_IDLE, S_READY, S_WAIT, S_CHECK, S_WON} ctrl_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/maze_tile_address.sv
// Tile coordinate to linear maze RAM address: WIDTH*y + x at 11 bits.
module maze_tile_address
  import maze_pkg::*;
#(
  parameter int WIDTH = MAZE_WIDTH
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [ADDR_W-1:0]  o_addr
);
  localparam logic [ADDR_W-1:0] W_ROW = ADDR_W'(WIDTH);

  assign o_addr = W_ROW * {5'd0, i_y} + {5'd0, i_x};
endmodule

// File: rtl/maze_player_controller.sv
// Player position controller: arbitrates move pulses, reads the target tile from
// maze RAM (2-cycle latency) and commits the move only onto FLOOR tiles.
module maze_player_controller
  import maze_pkg::*;
#(
  parameter int WIDTH   = MAZE_WIDTH,
  parameter int HEIGHT  = MAZE_HEIGHT,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_gen_end,
  input  logic               i_move_up,
  input  logic               i_move_down,
  input  logic               i_move_left,
  input  logic               i_move_right,
  output logic [ADDR_W-1:0]  o_maze_address,
  input  logic               i_maze_address_data,
  output logic [COORD_W-1:0] o_player_x,
  output logic [COORD_W-1:0] o_player_y,
  output logic               o_move_busy,
  output logic               o_at_exit,
  output logic [15:0]        o_move_count
);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);
  localparam logic [ADDR_W-1:0]  A_START = ADDR_W'(WIDTH * START_Y + START_X);

  // Exits sit on the last row, last two columns, but only the even one is opened.
  function automatic logic f_is_exit(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (y == Y_MAX) && ((x == X_MAX) || (x == X_MAX - 6'd1)) && !x[0];
  endfunction

  ctrl_state_e        r_state, w_state_nxt;
  logic [COORD_W-1:0] r_px, r_py, r_tx, r_ty;
  logic [COORD_W-1:0] w_px_nxt, w_py_nxt, w_tx_nxt, w_ty_nxt;
  logic               r_wcnt, w_wcnt_nxt;
  logic               r_busy, w_busy_nxt, r_exit, w_exit_nxt;
  logic [15:0]        r_moves, w_moves_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic               w_req, w_in_grid;
  dir_e               w_dir;
  logic [COORD_W-1:0] w_tgt_x, w_tgt_y, w_ax, w_ay;

  always_comb begin
    w_req = 1'b1;
    w_dir = DIR_UP;
    if (i_move_up)         w_dir = DIR_UP;
    else if (i_move_down)  w_dir = DIR_DOWN;
    else if (i_move_left)  w_dir = DIR_LEFT;
    else if (i_move_right) w_dir = DIR_RIGHT;
    else                   w_req = 1'b0;
  end

  // Off-grid checks happen on coordinates before any address is formed.
  always_comb begin
    w_tgt_x   = r_px;
    w_tgt_y   = r_py;
    w_in_grid = 1'b0;
    case (w_dir)
      DIR_UP:    begin w_in_grid = (r_py != '0);    w_tgt_y = r_py - 6'd1; end
      DIR_DOWN:  begin w_in_grid = (r_py != Y_MAX); w_tgt_y = r_py + 6'd1; end
      DIR_LEFT:  begin w_in_grid = (r_px != '0);    w_tgt_x = r_px - 6'd1; end
      DIR_RIGHT: begin w_in_grid = (r_px != X_MAX); w_tgt_x = r_px + 6'd1; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_tx_nxt    = r_tx;
    w_ty_nxt    = r_ty;
    w_wcnt_nxt  = r_wcnt;
    w_busy_nxt  = r_busy;
    w_exit_nxt  = r_exit;
    w_moves_nxt = r_moves;
    case (r_state)
      S_IDLE: if (i_gen_end) begin
        w_state_nxt = S_READY;
        w_px_nxt    = X_START;
        w_py_nxt    = Y_START;
        w_moves_nxt = '0;
        w_exit_nxt  = 1'b0;
      end
      S_READY: if (w_req && w_in_grid) begin
        w_state_nxt = S_WAIT;
        w_tx_nxt    = w_tgt_x;
        w_ty_nxt    = w_tgt_y;
        w_wcnt_nxt  = 1'b0;
        w_busy_nxt  = 1'b1;
      end
      S_WAIT: begin
        w_wcnt_nxt = 1'b1;
        if (r_wcnt) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_READY;
        if (i_maze_address_data == FLOOR) begin
          w_px_nxt    = r_tx;
          w_py_nxt    = r_ty;
          w_moves_nxt = sat_inc16(r_moves);
        end
        if (f_is_exit(w_px_nxt, w_py_nxt)) begin
          w_state_nxt = S_WON;
          w_exit_nxt  = 1'b1;
        end
      end
      S_WON: ;
      default: w_state_nxt = S_IDLE;
    endcase
    // Regeneration abandons whatever is in flight.
    if (!i_gen_end && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_px_nxt    = r_px;
      w_py_nxt    = r_py;
      w_moves_nxt = r_moves;
      w_busy_nxt  = 1'b0;
      w_exit_nxt  = 1'b0;
    end
  end

  assign w_ax = (w_state_nxt == S_WAIT) ? w_tx_nxt : w_px_nxt;
  assign w_ay = (w_state_nxt == S_WAIT) ? w_ty_nxt : w_py_nxt;

  maze_tile_address #(.WIDTH(WIDTH)) u_tile_addr (
    .i_x   (w_ax),
    .i_y   (w_ay),
    .o_addr(w_addr)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_px    <= X_START;
      r_py    <= Y_START;
      r_tx    <= X_START;
      r_ty    <= Y_START;
      r_wcnt  <= 1'b0;
      r_busy  <= 1'b0;
      r_exit  <= 1'b0;
      r_moves <= '0;
      r_addr  <= A_START;
    end else begin
      r_state <= w_state_nxt;
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      r_tx    <= w_tx_nxt;
      r_ty    <= w_ty_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_busy  <= w_busy_nxt;
      r_exit  <= w_exit_nxt;
      r_moves <= w_moves_nxt;
      r_addr  <= w_addr;
    end
  end

  assign o_maze_address = r_addr;
  assign o_player_x     = r_px;
  assign o_player_y     = r_py;
  assign o_move_busy    = r_busy;
  assign o_at_exit      = r_exit;
  assign o_move_count   = r_moves;
endmodule

// File: tb/tb_maze_player_controller.sv
// Bench for maze_player_controller: directed walk plus random requests, checked
// every cycle against a move-level model of the player.
module tb_maze_player_controller;
  localparam int W = 30;
  localparam int H = 40;
  localparam logic [3:0] MU = 4'b1000, MD = 4'b0100, ML = 4'b0010, MR = 4'b0001;

  logic        clk = 1'b0, rst = 1'b1, gen_end = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [10:0] addr;
  logic        data;
  logic [5:0]  px, py;
  logic        busy, at_exit;
  logic [15:0] mcount;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;
  bit maze [0:W*H-1];
  logic rd1 = 1'b1, rd2 = 1'b1;

  always #5 clk = ~clk;

  maze_player_controller #(.WIDTH(W), .HEIGHT(H), .START_X(0), .START_Y(0)) dut (
    .i_clock(clk), .i_reset(rst), .i_gen_end(gen_end),
    .i_move_up(up), .i_move_down(down), .i_move_left(left), .i_move_right(right),
    .o_maze_address(addr), .i_maze_address_data(data),
    .o_player_x(px), .o_player_y(py), .o_move_busy(busy),
    .o_at_exit(at_exit), .o_move_count(mcount)
  );

  // Maze RAM with two cycles of read latency.
  always @(posedge clk) begin
    rd1 <= (int'(addr) < W*H) ? maze[addr] : 1'b1;
    rd2 <= rd1;
  end
  assign data = rd2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a move accepted at one edge resolves three edges later; the target
  // address is shown for the two cycles the RAM needs.
  int mx = 0, my = 0, mtx = 0, mty = 0, mcnt = 0, mleft = 0;
  bit midle = 1'b1, mwon = 1'b0, mexit = 1'b0;

  always @(posedge clk) begin
    int tx, ty;
    bit req;
    if (rst) begin
      midle = 1; mwon = 0; mexit = 0; mx = 0; my = 0; mcnt = 0; mleft = 0;
    end else if (midle) begin
      if (gen_end) begin midle = 0; mx = 0; my = 0; mcnt = 0; mexit = 0; mwon = 0; end
    end else if (!gen_end) begin
      midle = 1; mleft = 0; mexit = 0; mwon = 0;
    end else if (mwon) begin
    end else if (mleft > 0) begin
      mleft--;
      if (mleft == 0) begin
        if (!maze[mty*W + mtx]) begin
          mx = mtx; my = mty;
          if (mcnt < 65535) mcnt++;
        end
        if (my == H-1 && (mx == W-2 || mx == W-1) && mx % 2 == 0) begin mwon = 1; mexit = 1; end
      end
    end else begin
      req = 1; tx = mx; ty = my;
      if (up) ty = my - 1;
      else if (down) ty = my + 1;
      else if (left) tx = mx - 1;
      else if (right) tx = mx + 1;
      else req = 0;
      if (req && tx >= 0 && tx < W && ty >= 0 && ty < H) begin mtx = tx; mty = ty; mleft = 3; end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("player_x", int'(px), mx);
      chk("player_y", int'(py), my);
      chk("move_count", int'(mcount), mcnt);
      chk("move_busy", int'(busy), (mleft > 0) ? 1 : 0);
      chk("at_exit", int'(at_exit), int'(mexit));
      chk("maze_address", int'(addr), (mleft >= 2) ? mty*W + mtx : my*W + mx);
    end
  end

  task automatic do_move(input logic [3:0] m, output int bcyc);
    @(negedge clk) {up, down, left, right} = m;
    @(negedge clk) {up, down, left, right} = 4'b0;
    bcyc = 0;
    while (busy && bcyc < 20) begin bcyc++; @(negedge clk); end
    if (bcyc >= 20) chk("busy_timeout", bcyc, 3);
  endtask

  initial begin
    int b;
    for (int i = 0; i < W*H; i++) maze[i] = 1'b1;
    for (int x = 0; x < W; x++) maze[x] = 1'b0;
    for (int y = 0; y < H; y++) maze[y*W + 28] = 1'b0;
    maze[30] = 1'b1;
    maze[31] = 1'b0; maze[32] = 1'b0; maze[33] = 1'b0;
    maze[61] = 1'b0; maze[62] = 1'b0; maze[63] = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_x", int'(px), 0);
    chk("reset_y", int'(py), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_count", int'(mcount), 0);
    gen_end = 1'b1;
    @(negedge clk);

    do_move(MD, b);                        // tile 30 is a wall
    chk("wall_y", int'(py), 0);
    chk("wall_count", int'(mcount), 0);
    do_move(MU, b);                        // off-grid
    chk("offgrid_busy_cycles", b, 0);
    chk("offgrid_addr", int'(addr), 0);
    do_move(MR, b);
    chk("floor_busy_cycles", b, 3);
    chk("floor_x", int'(px), 1);
    chk("floor_count", int'(mcount), 1);

    do_move(MR, b); do_move(MD, b); do_move(MD, b);
    chk("at22_x", int'(px), 2);
    chk("at22_y", int'(py), 2);
    @(negedge clk) {up, down, left, right} = MU | MR;
    @(negedge clk) {up, down, left, right} = ML;
    @(negedge clk) {up, down, left, right} = 4'b0;
    b = 0;
    while (busy && b < 20) begin b++; @(negedge clk); end
    chk("prio_x", int'(px), 2);
    chk("prio_y", int'(py), 1);
    chk("prio_count", int'(mcount), 5);

    @(negedge clk) right = 1'b1;
    @(negedge clk) begin right = 1'b0; gen_end = 1'b0; end
    @(negedge clk);
    chk("regen_busy", int'(busy), 0);
    gen_end = 1'b1;
    @(negedge clk);
    chk("regen_x", int'(px), 0);
    chk("regen_y", int'(py), 0);
    chk("regen_count", int'(mcount), 0);

    for (int i = 0; i < 28; i++) do_move(MR, b);
    for (int i = 0; i < 39; i++) do_move(MD, b);
    chk("exit_flag", int'(at_exit), 1);
    chk("exit_x", int'(px), 28);
    chk("exit_y", int'(py), 39);
    do_move(ML, b);
    do_move(MU, b);
    chk("won_busy_cycles", b, 0);
    chk("won_x", int'(px), 28);
    chk("won_count", int'(mcount), 67);

    for (int it = 0; it < 6; it++) begin
      @(negedge clk) gen_end = 1'b0;
      for (int i = 0; i < W*H; i++) maze[i] = ($urandom_range(0, 3) == 0);
      for (int x = 0; x < W; x++) maze[x] = 1'b0;
      @(negedge clk) gen_end = 1'b1;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        {up, down, left, right} = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
        gen_end = ($urandom_range(0, 299) != 0);
      end
      {up, down, left, right} = 4'b0;
    end
    gen_end = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
